semaforo_multi: RTL and testbench
=================================

Name: semaforo_multi

Overview:
Parametrised traffic-light controller for N_DIR approaches with round-robin green phases, all-red clearance, a latched pedestrian request and a night flashing-yellow mode. A 1 s tick is derived from the board clock by an internal prescaler. The remaining seconds of the current phase are shown on two active-low 7-segment digits. The block sits directly under the board top-level wrapper; switches and keys map onto its mode, request and config inputs.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick; benches use 4
N_DIR, 2, number of approaches, legal range 2..4
GREEN_S, 10, green duration in ticks, legal range 1..99
YELLOW_S, 3, yellow duration in ticks, legal range 1..99
ALLRED_S, 1, all-red clearance in ticks, legal range 1..99
PED_S, 8, pedestrian walk duration in ticks, legal range 1..99

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ped_n  in  1  raw pedestrian button, active-low; synchronised internally with 2 flip-flops plus falling-edge detect
night  in  1  night-mode request level
green  out  N_DIR  green lamp per approach
yellow  out  N_DIR  yellow lamp per approach
red  out  N_DIR  red lamp per approach
walk  out  1  pedestrian walk lamp
ped_pending  out  1  request latched and waiting for service
phase  out  3  0=ALLRED, 1=GREEN, 2=YELLOW, 3=PED, 4=NIGHT
dir  out  2  current approach index
countdown  out  7  remaining ticks in the current phase
hex1  out  7  tens digit of countdown, segments gfedcba, active-low
hex0  out  7  ones digit of countdown, segments gfedcba, active-low

Behaviour:
- Reset (async): phase=ALLRED, dir=0, countdown=ALLRED_S, prescaler=0, ped_pending=0. Outputs: red=all 1, green=0, yellow=0, walk=0, flash=0.
- Prescaler counts 0..TICK_DIV-1. tick is a 1-cycle pulse when the count wraps.
- All outputs are registered. Lamps are decoded from the registered state, so they change one cycle after the state update.
- Countdown timing:
  - On entry to a phase, countdown loads that phase's duration.
  - On each tick, countdown decrements. If countdown==1 at the tick, the phase transition occurs on that tick instead.
  - So every phase lasts exactly its duration in ticks.
- Transitions, evaluated on the tick that ends a phase:
  - GREEN -> YELLOW, same dir.
  - YELLOW -> ALLRED.
  - ALLRED with night=1 -> NIGHT.
  - ALLRED with ped_pending=1, not after PED -> PED.
  - Otherwise ALLRED -> GREEN with dir = next approach (wraps N_DIR-1 -> 0). The first ALLRED after reset goes to GREEN dir=0, not dir=1.
  - PED -> ALLRED. An internal after_ped flag ensures the ALLRED that follows PED always proceeds to GREEN.
- Lamps per phase:
  - GREEN / YELLOW: green[dir] or yellow[dir] = 1; all other approaches red.
  - ALLRED and PED: all red. walk=1 only in PED.
- Pedestrian request:
  - ped_pending sets on a synchronised falling edge in any phase except PED and NIGHT; presses in PED or NIGHT are ignored.
  - Clears in the cycle PED is entered.
  - If a set and the PED entry coincide, the clear wins.
- NIGHT:
  - red=0, green=0. yellow = all lamps driven from a flash register that toggles on every tick.
  - countdown=0, both hex digits show 0.
  - On the tick with night=0, go to ALLRED, dir=N_DIR-1, so the next green is dir 0. The flash register clears.
  - night rising mid-phase does not abort the phase; it takes effect only at the end of the next ALLRED.
- Display: countdown in 0..99 is split into tens/ones (combinational divide by 10) and decoded to 7-seg. The 7-bit width holds 99 max.
- Reset asserted mid-phase returns to the reset state immediately. The prescaler restarts, so the first tick is TICK_DIV cycles after release.

Test Plan:
- TICK_DIV=4, N_DIR=2, no inputs, reset 3 cycles -> sequence ALLRED(1) G0(10) Y0(3) ALLRED(1) G1(10) Y1(3) ALLRED, then repeats. Check tick counts and red/green/yellow vectors each phase (e.g. G0: green=01, red=10).
- Press ped_n low 2 cycles during G0 -> ped_pending=1 one cycle after the synchroniser edge. After Y0: ALLRED(1), PED(8) with walk=1, red=11, pending cleared; then ALLRED(1) -> G1.
- Second press during PED and a press during NIGHT -> no latch, ped_pending stays 0.
- night=1 during G1 -> Y1 and ALLRED complete, then NIGHT with yellow toggling 11/00 each tick and countdown=0. night=0 -> ALLRED then G0.
- GREEN_S=25, check during green -> countdown 25 shows hex1=0100100 ('2'), hex0=0010010 ('5'); at countdown 9, hex1='0' (1000000).
- N_DIR=4 -> dir walks 0,1,2,3,0. Reset asserted mid-Y2 -> same cycle: red=1111, countdown=1, dir=0.

Source files
------------

// File: rtl/semaforo_multi.sv
// semaforo_multi: round-robin traffic-light controller with all-red
// clearance, latched pedestrian walk phase and night flashing yellow.
module semaforo_multi #(
  parameter int TICK_DIV = 50000000,
  parameter int N_DIR    = 2,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int PED_S    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_n,
  input  logic             night,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] red,
  output logic             walk,
  output logic             ped_pending,
  output logic [2:0]       phase,
  output logic [1:0]       dir,
  output logic [6:0]       countdown,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0
);

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    PED    = 3'd3,
    NIGHT  = 3'd4
  } phase_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [1:0] LAST_DIR = 2'(N_DIR - 1);
  localparam logic [6:0] T_G = 7'(GREEN_S);
  localparam logic [6:0] T_Y = 7'(YELLOW_S);
  localparam logic [6:0] T_A = 7'(ALLRED_S);
  localparam logic [6:0] T_P = 7'(PED_S);

  // 7-segment pattern, gfedcba, active-low
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pre_q;
  logic          tick;
  logic [2:0]    sync_q;
  logic          fall;

  phase_t     phase_q, phase_d;
  logic [1:0] dir_q, dir_d;
  logic [6:0] cnt_q, cnt_d;
  logic       after_ped_q, after_ped_d;
  logic       first_q, first_d;
  logic       flash_q, flash_d;
  logic       pend_q;
  logic       enter_ped;
  logic [1:0] next_dir;

  logic [N_DIR-1:0] g_d, y_d, r_d;
  logic             w_d;
  logic [3:0]       tens, ones;

  assign tick = (pre_q == PRE_MAX);

  // prescaler: one tick pulse per TICK_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  // button synchroniser plus one stage for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], ped_n};
  end

  assign fall = sync_q[2] & ~sync_q[1];

  assign next_dir = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;

  // phase sequencing, evaluated only on ticks
  always_comb begin
    phase_d     = phase_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    after_ped_d = after_ped_q;
    first_d     = first_q;
    flash_d     = flash_q;
    enter_ped   = 1'b0;
    if (tick) begin
      if (phase_q == NIGHT) begin
        flash_d = ~flash_q;
        if (!night) begin
          phase_d = ALLRED;
          dir_d   = LAST_DIR;
          cnt_d   = T_A;
          flash_d = 1'b0;
        end
      end else if (cnt_q > 7'd1) begin
        cnt_d = cnt_q - 7'd1;
      end else begin
        unique case (phase_q)
          GREEN: begin
            phase_d = YELLOW;
            cnt_d   = T_Y;
          end
          YELLOW: begin
            phase_d = ALLRED;
            cnt_d   = T_A;
          end
          PED: begin
            phase_d     = ALLRED;
            cnt_d       = T_A;
            after_ped_d = 1'b1;
          end
          default: begin
            if (!after_ped_q && night) begin
              phase_d = NIGHT;
              cnt_d   = 7'd0;
              flash_d = 1'b0;
            end else if (!after_ped_q && pend_q) begin
              phase_d   = PED;
              cnt_d     = T_P;
              enter_ped = 1'b1;
            end else begin
              phase_d     = GREEN;
              cnt_d       = T_G;
              dir_d       = first_q ? 2'd0 : next_dir;
              first_d     = 1'b0;
              after_ped_d = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= ALLRED;
      dir_q       <= 2'd0;
      cnt_q       <= T_A;
      after_ped_q <= 1'b0;
      first_q     <= 1'b1;
      flash_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      after_ped_q <= after_ped_d;
      first_q     <= first_d;
      flash_q     <= flash_d;
    end
  end

  // pedestrian latch: clearing on PED entry beats a new press
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_q <= 1'b0;
    else if (enter_ped)
      pend_q <= 1'b0;
    else if (fall && phase_q != PED && phase_q != NIGHT)
      pend_q <= 1'b1;
  end

  // lamp decode from the registered phase
  always_comb begin
    g_d = '0;
    y_d = '0;
    r_d = '1;
    w_d = (phase_q == PED);
    if (phase_q == NIGHT) begin
      r_d = '0;
      y_d = {N_DIR{flash_q}};
    end else begin
      for (int i = 0; i < N_DIR; i++) begin
        if (dir_q == 2'(i)) begin
          if (phase_q == GREEN) begin
            g_d[i] = 1'b1;
            r_d[i] = 1'b0;
          end else if (phase_q == YELLOW) begin
            y_d[i] = 1'b1;
            r_d[i] = 1'b0;
          end
        end
      end
    end
  end

  assign tens = 4'(cnt_q / 7'd10);
  assign ones = 4'(cnt_q % 7'd10);

  // registered lamp and display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      green  <= '0;
      yellow <= '0;
      red    <= '1;
      walk   <= 1'b0;
      hex1   <= seg(4'(ALLRED_S / 10));
      hex0   <= seg(4'(ALLRED_S % 10));
    end else begin
      green  <= g_d;
      yellow <= y_d;
      red    <= r_d;
      walk   <= w_d;
      hex1   <= seg(tens);
      hex0   <= seg(ones);
    end
  end

  assign phase       = phase_q;
  assign dir         = dir_q;
  assign countdown   = cnt_q;
  assign ped_pending = pend_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// tb_semaforo_multi: directed checks of semaforo_multi in three
// configurations (2 approaches, long green, 4 approaches).
module tb_semaforo_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_x = 1'b0;
  logic ped_n = 1'b1;
  logic night = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] g_a, y_a, r_a;
  logic       w_a, p_a;
  logic [2:0] ph_a;
  logic [1:0] d_a;
  logic [6:0] c_a, h1_a, h0_a;

  logic [1:0] g_b, y_b, r_b;
  logic       w_b, p_b;
  logic [2:0] ph_b;
  logic [1:0] d_b;
  logic [6:0] c_b, h1_b, h0_b;

  logic [3:0] g_c, y_c, r_c;
  logic       w_c, p_c;
  logic [2:0] ph_c;
  logic [1:0] d_c;
  logic [6:0] c_c, h1_c, h0_c;

  always #5 clk = ~clk;

  semaforo_multi #(.TICK_DIV(4), .N_DIR(2)) dut_a (
    .clk(clk), .rst(rst), .ped_n(ped_n), .night(night),
    .green(g_a), .yellow(y_a), .red(r_a), .walk(w_a),
    .ped_pending(p_a), .phase(ph_a), .dir(d_a),
    .countdown(c_a), .hex1(h1_a), .hex0(h0_a)
  );

  semaforo_multi #(.TICK_DIV(4), .N_DIR(2), .GREEN_S(25)) dut_b (
    .clk(clk), .rst(rst), .ped_n(1'b1), .night(1'b0),
    .green(g_b), .yellow(y_b), .red(r_b), .walk(w_b),
    .ped_pending(p_b), .phase(ph_b), .dir(d_b),
    .countdown(c_b), .hex1(h1_b), .hex0(h0_b)
  );

  semaforo_multi #(.TICK_DIV(4), .N_DIR(4)) dut_c (
    .clk(clk), .rst(rst | rst_x), .ped_n(1'b1), .night(1'b0),
    .green(g_c), .yellow(y_c), .red(r_c), .walk(w_c),
    .ped_pending(p_c), .phase(ph_c), .dir(d_c),
    .countdown(c_c), .hex1(h1_c), .hex0(h0_c)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // sample point for tick k: state and lamps both settled
  task automatic to_tick(input int k);
    step(4 * k + 1 - cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic press();
    ped_n = 1'b0;
    step(2);
    ped_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ph_a, d_a, c_a} !== {3'd0, 2'd0, 7'd1}) begin
      errors++;
      $display("FAIL reset_state got %h want %h",
               {ph_a, d_a, c_a}, {3'd0, 2'd0, 7'd1});
    end
    checks++;
    if ({g_a, y_a, r_a, w_a, p_a} !== 8'b00_00_11_0_0) begin
      errors++;
      $display("FAIL reset_lamps got %b want 00001100",
               {g_a, y_a, r_a, w_a, p_a});
    end
    checks++;
    if ({h1_a, h0_a} !== {7'b1000000, 7'b1111001}) begin
      errors++;
      $display("FAIL reset_hex got %b %b want 1000000 1111001",
               h1_a, h0_a);
    end
    checks++;
    if ({g_c, y_c, r_c} !== 12'b0000_0000_1111) begin
      errors++;
      $display("FAIL reset_lamps4 got %b want 000000001111",
               {g_c, y_c, r_c});
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_sequence();
    int tk[10] = '{0, 1, 10, 11, 13, 14, 15, 25, 28, 29};
    logic [11:0] es[10] = '{
      {3'd0, 2'd0, 7'd1},  {3'd1, 2'd0, 7'd10},
      {3'd1, 2'd0, 7'd1},  {3'd2, 2'd0, 7'd3},
      {3'd2, 2'd0, 7'd1},  {3'd0, 2'd0, 7'd1},
      {3'd1, 2'd1, 7'd10}, {3'd2, 2'd1, 7'd3},
      {3'd0, 2'd1, 7'd1},  {3'd1, 2'd0, 7'd10}};
    logic [5:0] el[10] = '{
      6'b00_00_11, 6'b01_00_10, 6'b01_00_10, 6'b00_01_10,
      6'b00_01_10, 6'b00_00_11, 6'b10_00_01, 6'b00_10_01,
      6'b00_00_11, 6'b01_00_10};
    for (int i = 0; i < 10; i++) begin
      to_tick(tk[i]);
      checks++;
      if ({ph_a, d_a, c_a} !== es[i]) begin
        errors++;
        $display("FAIL seq_state t=%0d got %h want %h",
                 tk[i], {ph_a, d_a, c_a}, es[i]);
      end
      checks++;
      if ({g_a, y_a, r_a} !== el[i]) begin
        errors++;
        $display("FAIL seq_lamps t=%0d got %b want %b",
                 tk[i], {g_a, y_a, r_a}, el[i]);
      end
    end
  endtask

  task automatic test_display();
    int tk[3] = '{1, 17, 20};
    logic [6:0] ec[3] = '{7'd25, 7'd9, 7'd6};
    logic [13:0] eh[3] = '{
      {7'b0100100, 7'b0010010},
      {7'b1000000, 7'b0010000},
      {7'b1000000, 7'b0000010}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      to_tick(tk[i]);
      if (i == 0) begin
        checks++;
        if ({h1_a, h0_a} !== {7'b1111001, 7'b1000000}) begin
          errors++;
          $display("FAIL hex_ten got %b %b want 1111001 1000000",
                   h1_a, h0_a);
        end
      end
      checks++;
      if (c_b !== ec[i]) begin
        errors++;
        $display("FAIL disp_cnt t=%0d got %0d want %0d",
                 tk[i], c_b, ec[i]);
      end
      checks++;
      if ({h1_b, h0_b} !== eh[i]) begin
        errors++;
        $display("FAIL disp_hex t=%0d got %b want %b",
                 tk[i], {h1_b, h0_b}, eh[i]);
      end
    end
  endtask

  task automatic test_ped();
    int tk[5] = '{14, 15, 22, 23, 24};
    logic [11:0] es[5] = '{
      {3'd0, 2'd0, 7'd1}, {3'd3, 2'd0, 7'd8},
      {3'd3, 2'd0, 7'd1}, {3'd0, 2'd0, 7'd1},
      {3'd1, 2'd1, 7'd10}};
    logic [7:0] el[5] = '{
      8'b00_00_11_0_1, 8'b00_00_11_1_0, 8'b00_00_11_1_0,
      8'b00_00_11_0_0, 8'b10_00_01_0_0};
    do_reset();
    to_tick(2);
    press();
    checks++;
    if (p_a !== 1'b0) begin
      errors++;
      $display("FAIL ped_early got %b want 0", p_a);
    end
    step(1);
    checks++;
    if (p_a !== 1'b1) begin
      errors++;
      $display("FAIL ped_latch got %b want 1", p_a);
    end
    for (int i = 0; i < 5; i++) begin
      to_tick(tk[i]);
      checks++;
      if ({ph_a, d_a, c_a} !== es[i]) begin
        errors++;
        $display("FAIL ped_state t=%0d got %h want %h",
                 tk[i], {ph_a, d_a, c_a}, es[i]);
      end
      checks++;
      if ({g_a, y_a, r_a, w_a, p_a} !== el[i]) begin
        errors++;
        $display("FAIL ped_lamps t=%0d got %b want %b",
                 tk[i], {g_a, y_a, r_a, w_a, p_a}, el[i]);
      end
      if (tk[i] == 15) begin
        to_tick(16);
        press();
        step(3);
        checks++;
        if (p_a !== 1'b0) begin
          errors++;
          $display("FAIL ped_in_ped got %b want 0", p_a);
        end
      end
    end
  endtask

  task automatic test_night();
    int tk[8] = '{27, 34, 37, 38, 39, 41, 42, 43};
    logic [11:0] es[8] = '{
      {3'd1, 2'd1, 7'd7}, {3'd2, 2'd1, 7'd3},
      {3'd0, 2'd1, 7'd1}, {3'd4, 2'd1, 7'd0},
      {3'd4, 2'd1, 7'd0}, {3'd4, 2'd1, 7'd0},
      {3'd0, 2'd1, 7'd1}, {3'd1, 2'd0, 7'd10}};
    logic [5:0] el[8] = '{
      6'b10_00_01, 6'b00_10_01, 6'b00_00_11, 6'b00_00_00,
      6'b00_11_00, 6'b00_11_00, 6'b00_00_11, 6'b01_00_10};
    to_tick(26);
    night = 1'b1;
    for (int i = 0; i < 8; i++) begin
      to_tick(tk[i]);
      checks++;
      if ({ph_a, d_a, c_a} !== es[i]) begin
        errors++;
        $display("FAIL night_state t=%0d got %h want %h",
                 tk[i], {ph_a, d_a, c_a}, es[i]);
      end
      checks++;
      if ({g_a, y_a, r_a} !== el[i]) begin
        errors++;
        $display("FAIL night_lamps t=%0d got %b want %b",
                 tk[i], {g_a, y_a, r_a}, el[i]);
      end
      if (tk[i] == 38) begin
        checks++;
        if ({h1_a, h0_a} !== {7'b1000000, 7'b1000000}) begin
          errors++;
          $display("FAIL night_hex got %b %b want 1000000 1000000",
                   h1_a, h0_a);
        end
      end
      if (tk[i] == 39) begin
        press();
        step(3);
        checks++;
        if (p_a !== 1'b0) begin
          errors++;
          $display("FAIL ped_in_night got %b want 0", p_a);
        end
      end
      if (tk[i] == 41) night = 1'b0;
    end
  endtask

  task automatic test_dir4();
    int tk[5] = '{15, 29, 43, 57, 96};
    logic [11:0] es[5] = '{
      {3'd1, 2'd1, 7'd10}, {3'd1, 2'd2, 7'd10},
      {3'd1, 2'd3, 7'd10}, {3'd1, 2'd0, 7'd10},
      {3'd2, 2'd2, 7'd2}};
    logic [11:0] el[5] = '{
      12'b0010_0000_1101, 12'b0100_0000_1011,
      12'b1000_0000_0111, 12'b0001_0000_1110,
      12'b0000_0100_1011};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      to_tick(tk[i]);
      checks++;
      if ({ph_c, d_c, c_c} !== es[i]) begin
        errors++;
        $display("FAIL dir4_state t=%0d got %h want %h",
                 tk[i], {ph_c, d_c, c_c}, es[i]);
      end
      checks++;
      if ({g_c, y_c, r_c} !== el[i]) begin
        errors++;
        $display("FAIL dir4_lamps t=%0d got %b want %b",
                 tk[i], {g_c, y_c, r_c}, el[i]);
      end
    end
    step(2);
    rst_x = 1'b1;
    #1;
    checks++;
    if ({ph_c, d_c, c_c, r_c, g_c, y_c} !==
        {3'd0, 2'd0, 7'd1, 4'b1111, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL midreset got %h want %h",
               {ph_c, d_c, c_c, r_c, g_c, y_c},
               {3'd0, 2'd0, 7'd1, 4'b1111, 4'b0000, 4'b0000});
    end
    @(negedge clk);
    rst_x = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ph_c, c_c} !== {3'd0, 7'd1}) begin
      errors++;
      $display("FAIL prescale_early got %h want %h",
               {ph_c, c_c}, {3'd0, 7'd1});
    end
    @(negedge clk);
    checks++;
    if ({ph_c, d_c, c_c} !== {3'd1, 2'd0, 7'd10}) begin
      errors++;
      $display("FAIL prescale_tick got %h want %h",
               {ph_c, d_c, c_c}, {3'd1, 2'd0, 7'd10});
    end
    @(negedge clk);
    checks++;
    if ({g_c, r_c} !== {4'b0001, 4'b1110}) begin
      errors++;
      $display("FAIL lamp_lag got %b want 00011110", {g_c, r_c});
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_display();
    test_ped();
    test_night();
    test_dir4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
